// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// over 3-5 states, with optional memory wait states, addi/bne support and trapping.
module multicycle_control #(
  parameter bit USE_MEM_READY   = 1'b1,
  parameter bit ENABLE_ADDI     = 1'b1,
  parameter bit ENABLE_BNE      = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e state_q, state_d;
  logic   ready;

  assign ready = mem_ready | ~USE_MEM_READY;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpRtype:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpBne:      state_d = ENABLE_BNE ? StBranch : StTrap;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = ENABLE_ADDI ? StAddiEx : StTrap;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Opcode is re-read here; anything other than lw/sw is treated as illegal.
        if (opcode == OpLw)      state_d = StMemRd;
        else if (opcode == OpSw) state_d = StMemWr;
        else                     state_d = StTrap;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = ready;
        if (ready) state_d = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OpBne);
        instr_done    = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StTrap: begin
        illegal = 1'b1;
        state_d = HALT_ON_ILLEGAL ? StTrap : StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset suppresses every strobe, including FETCH's ready-gated loads.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

endmodule
